rca_lsq: RTL and testbench

- In-order load/store queue for the reconfigurable compute accelerator (RCA).
- It is the responder side of the operation-unit LSQ interface: it accepts `new_request` transactions from one OU, buffers them in a FIFO and issues them one at a time to the data-memory port.
- For loads it aligns, extends and returns the load result with a one-cycle `load_complete` pulse; stores complete silently.

---
 rtl/rca_lsq.sv | 200 ++++++++++++++++++++
 tb/tb_rca_lsq.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rca_lsq.sv
// rca_lsq: in-order load/store queue for the RCA operation units.
// Accepts OU requests into a small FIFO and issues them one at a time
// to the data-memory port. Load results are lane-selected, extended and
// returned with a one-cycle load_complete pulse; stores complete silently.
// The lane logic assumes a 32-bit data path (four byte lanes, mem_be[3:0]).
module rca_lsq #(
   parameter int DEPTH = 4,
   parameter int XLEN  = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] addr,
   input  logic [XLEN-1:0] data,
   input  logic [2:0]      fn3,
   input  logic            load,
   input  logic            store,
   input  logic            new_request,
   output logic            lsq_full,
   output logic [XLEN-1:0] load_data,
   output logic            load_complete,
   output logic            mem_request,
   output logic [XLEN-1:0] mem_addr,
   output logic [XLEN-1:0] mem_wdata,
   output logic [3:0]      mem_be,
   output logic            mem_load,
   output logic            mem_store,
   input  logic            mem_ack,
   input  logic [XLEN-1:0] mem_rdata,
   input  logic            mem_rvalid
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   typedef enum logic {
      ISSUE     = 1'b0,
      WAIT_LOAD = 1'b1
   } state_t;

   // Lane-replicated store data for the requested access size.
   function automatic logic [XLEN-1:0] store_wdata(input logic [2:0] f,
                                                   input logic [XLEN-1:0] d);
      logic [XLEN-1:0] w;
      case (f)
         3'b000:  w = {4{d[7:0]}};
         3'b001:  w = {2{d[15:0]}};
         default: w = d;
      endcase
      return w;
   endfunction

   // Byte enables; sizes other than byte/half are issued as full words.
   function automatic logic [3:0] store_be(input logic [2:0] f,
                                           input logic [1:0] a);
      logic [3:0] be;
      case (f)
         3'b000:  be = 4'b0001 << a;
         3'b001:  be = a[1] ? 4'b1100 : 4'b0011;
         default: be = 4'b1111;
      endcase
      return be;
   endfunction

   // Select the addressed lane of the read word and sign/zero extend it.
   function automatic logic [XLEN-1:0] load_extend(input logic [2:0] f,
                                                   input logic [1:0] a,
                                                   input logic [XLEN-1:0] rd);
      logic [7:0]      b;
      logic [15:0]     h;
      logic [XLEN-1:0] r;
      case (a)
         2'd0:    b = rd[7:0];
         2'd1:    b = rd[15:8];
         2'd2:    b = rd[23:16];
         default: b = rd[31:24];
      endcase
      h = a[1] ? rd[31:16] : rd[15:0];
      case (f)
         3'b000:  r = {{(XLEN-8){b[7]}}, b};
         3'b100:  r = {{(XLEN-8){1'b0}}, b};
         3'b001:  r = {{(XLEN-16){h[15]}}, h};
         3'b101:  r = {{(XLEN-16){1'b0}}, h};
         default: r = rd;
      endcase
      return r;
   endfunction

   // FIFO storage (no reset needed: entries are only read when counted valid)
   logic [XLEN-1:0] addr_q [DEPTH];
   logic [XLEN-1:0] data_q [DEPTH];
   logic [2:0]      fn3_q  [DEPTH];
   logic            load_q [DEPTH];

   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   state_t          state_q, state_d;
   logic [XLEN-1:0] load_data_q, load_data_d;
   logic            load_complete_q, load_complete_d;

   logic            empty;
   logic            push;
   logic            pop;
   logic [XLEN-1:0] head_addr;
   logic [XLEN-1:0] head_data;
   logic [2:0]      head_fn3;
   logic            head_load;

   assign empty     = (count_q == '0);
   assign lsq_full  = (count_q == FULL_CNT);
   // A request made while full is dropped even if the head pops this cycle.
   assign push      = new_request && !lsq_full && (load != store);

   assign head_addr = addr_q[rd_ptr_q];
   assign head_data = data_q[rd_ptr_q];
   assign head_fn3  = fn3_q[rd_ptr_q];
   assign head_load = load_q[rd_ptr_q];

   // Memory-side outputs: decoded from the head entry, zero when idle.
   assign mem_request = (state_q == ISSUE) && !empty;
   assign mem_addr    = mem_request ? {head_addr[XLEN-1:2], 2'b00} : '0;
   assign mem_wdata   = (mem_request && !head_load) ? store_wdata(head_fn3, head_data) : '0;
   assign mem_be      = (mem_request && !head_load) ? store_be(head_fn3, head_addr[1:0]) : 4'b0000;
   assign mem_load    = mem_request && head_load;
   assign mem_store   = mem_request && !head_load;

   assign load_data     = load_data_q;
   assign load_complete = load_complete_q;

   // FIFO entry write on push
   always_ff @(posedge clk) begin
      if (push) begin
         addr_q[wr_ptr_q] <= addr;
         data_q[wr_ptr_q] <= data;
         fn3_q[wr_ptr_q]  <= fn3;
         load_q[wr_ptr_q] <= load;
      end
   end

   // Issue FSM next state, pop decision and load result capture
   always_comb begin
      state_d         = state_q;
      pop             = 1'b0;
      load_complete_d = 1'b0;
      load_data_d     = load_data_q;
      case (state_q)
         ISSUE: begin
            if (!empty && mem_ack) begin
               if (head_load) begin
                  state_d = WAIT_LOAD;
               end else begin
                  pop = 1'b1;
               end
            end
         end
         WAIT_LOAD: begin
            if (mem_rvalid) begin
               pop             = 1'b1;
               load_complete_d = 1'b1;
               load_data_d     = load_extend(head_fn3, head_addr[1:0], mem_rdata);
               state_d         = ISSUE;
            end
         end
         default: state_d = ISSUE;
      endcase
   end

   // Pointer and occupancy next state; pointers wrap modulo DEPTH
   always_comb begin
      rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      count_d  = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Control and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= ISSUE;
         rd_ptr_q        <= '0;
         wr_ptr_q        <= '0;
         count_q         <= '0;
         load_data_q     <= '0;
         load_complete_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         rd_ptr_q        <= rd_ptr_d;
         wr_ptr_q        <= wr_ptr_d;
         count_q         <= count_d;
         load_data_q     <= load_data_d;
         load_complete_q <= load_complete_d;
      end
   end

endmodule

// File: tb/tb_rca_lsq.sv
// Testbench for rca_lsq: directed scenarios plus a randomized run checked
// against a transaction-level queue model.
module tb_rca_lsq;
   localparam int DEPTH = 4;
   localparam int XLEN  = 32;

   logic            clk = 1'b0;
   logic            rst;
   logic [XLEN-1:0] addr, data, load_data, mem_addr, mem_wdata, mem_rdata;
   logic [2:0]      fn3;
   logic            load, store, new_request, lsq_full, load_complete;
   logic            mem_request, mem_load, mem_store, mem_ack, mem_rvalid;
   logic [3:0]      mem_be;

   int n_cmp = 0;
   int n_bad = 0;

   rca_lsq #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
      .clk(clk), .rst(rst), .addr(addr), .data(data), .fn3(fn3),
      .load(load), .store(store), .new_request(new_request),
      .lsq_full(lsq_full), .load_data(load_data), .load_complete(load_complete),
      .mem_request(mem_request), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_be(mem_be), .mem_load(mem_load), .mem_store(mem_store),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [31:0] d;
      logic [2:0]  f;
      logic        ld;
   } req_t;

   function automatic logic [31:0] m_wdata(input logic [2:0] f, input logic [31:0] d);
      if (f == 3'd0) return (d & 32'hFF) * 32'h01010101;
      if (f == 3'd1) return (d & 32'hFFFF) * 32'h00010001;
      return d;
   endfunction

   function automatic logic [3:0] m_be(input logic [2:0] f, input logic [31:0] a);
      if (f == 3'd0) return 4'(1 << (a % 4));
      if (f == 3'd1) return ((a % 4) >= 2) ? 4'hC : 4'h3;
      return 4'hF;
   endfunction

   function automatic logic [31:0] m_load(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] r);
      logic [31:0] b, h;
      b = (r >> ((a % 4) * 8)) & 32'hFF;
      h = (r >> (((a % 4) >= 2) ? 16 : 0)) & 32'hFFFF;
      case (f)
         3'd0:    return (b >= 128) ? b + 32'hFFFFFF00 : b;
         3'd4:    return b;
         3'd1:    return (h >= 32768) ? h + 32'hFFFF0000 : h;
         3'd5:    return h;
         default: return r;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      new_request = 0; load = 0; store = 0; addr = '0; data = '0; fn3 = '0;
      mem_ack = 0; mem_rvalid = 0; mem_rdata = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1;
      tick();
      tick();
      rst = 0;
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++; if ({mem_request, lsq_full, load_complete, mem_load, mem_store} !== 5'b0) begin
         n_bad++; $display("FAIL reset_ctrl got=%b exp=00000",
                           {mem_request, lsq_full, load_complete, mem_load, mem_store}); end
      n_cmp++; if (load_data !== 32'h0) begin
         n_bad++; $display("FAIL reset_load_data got=%h exp=0", load_data); end
      n_cmp++; if ({mem_addr, mem_wdata, mem_be} !== 68'h0) begin
         n_bad++; $display("FAIL reset_mem_bus got=%h/%h/%h exp=0", mem_addr, mem_wdata, mem_be); end
   endtask

   task automatic test_sw();
      do_reset();
      new_request = 1; store = 1; addr = 32'h100; data = 32'hDEADBEEF; fn3 = 3'b010; mem_ack = 1;
      tick();
      new_request = 0; store = 0;
      n_cmp++; if (mem_request !== 1'b1 || mem_store !== 1'b1) begin
         n_bad++; $display("FAIL sw_req got=%b%b exp=11", mem_request, mem_store); end
      n_cmp++; if (mem_addr !== 32'h100) begin
         n_bad++; $display("FAIL sw_addr got=%h exp=00000100", mem_addr); end
      n_cmp++; if (mem_be !== 4'b1111) begin
         n_bad++; $display("FAIL sw_be got=%b exp=1111", mem_be); end
      n_cmp++; if (mem_wdata !== 32'hDEADBEEF) begin
         n_bad++; $display("FAIL sw_wdata got=%h exp=deadbeef", mem_wdata); end
      tick();
      mem_ack = 0;
      n_cmp++; if (mem_request !== 1'b0 || load_complete !== 1'b0) begin
         n_bad++; $display("FAIL sw_done got=%b%b exp=00", mem_request, load_complete); end
   endtask

   task automatic test_load(input logic [2:0] f, input logic [31:0] exp);
      do_reset();
      new_request = 1; load = 1; addr = 32'h203; fn3 = f; mem_ack = 1;
      tick();
      new_request = 0; load = 0;
      n_cmp++; if (mem_request !== 1'b1 || mem_load !== 1'b1 || mem_addr !== 32'h200) begin
         n_bad++; $display("FAIL ld_issue got=%b%b %h exp=11 00000200", mem_request, mem_load, mem_addr); end
      tick();
      mem_ack = 0;
      n_cmp++; if (mem_request !== 1'b0 || load_complete !== 1'b0) begin
         n_bad++; $display("FAIL ld_wait got=%b%b exp=00", mem_request, load_complete); end
      tick();
      mem_rvalid = 1; mem_rdata = 32'h80FFFFFF;
      n_cmp++; if (load_complete !== 1'b0) begin
         n_bad++; $display("FAIL ld_early got=%b exp=0", load_complete); end
      tick();
      mem_rvalid = 0; mem_rdata = '0;
      n_cmp++; if (load_complete !== 1'b1 || load_data !== exp) begin
         n_bad++; $display("FAIL ld_result got=%b %h exp=1 %h", load_complete, load_data, exp); end
      tick();
      n_cmp++; if (load_complete !== 1'b0 || load_data !== exp) begin
         n_bad++; $display("FAIL ld_hold got=%b %h exp=0 %h", load_complete, load_data, exp); end
   endtask

   task automatic test_sh();
      do_reset();
      new_request = 1; store = 1; addr = 32'h12; data = 32'h1234; fn3 = 3'b001;
      tick();
      new_request = 0; store = 0;
      n_cmp++; if (mem_addr !== 32'h10 || mem_be !== 4'b1100 || mem_wdata !== 32'h12341234) begin
         n_bad++; $display("FAIL sh_bus got=%h %b %h exp=00000010 1100 12341234", mem_addr, mem_be, mem_wdata); end
      mem_ack = 1;
      tick();
      mem_ack = 0;
      n_cmp++; if (mem_request !== 1'b0) begin
         n_bad++; $display("FAIL sh_pop got=%b exp=0", mem_request); end
   endtask

   task automatic test_full();
      do_reset();
      for (int i = 0; i < 4; i++) begin
         new_request = 1; store = 1; fn3 = 3'b010; addr = 32'h40 + 4 * i; data = i;
         tick();
      end
      n_cmp++; if (lsq_full !== 1'b1) begin
         n_bad++; $display("FAIL full_set got=%b exp=1", lsq_full); end
      addr = 32'h500; data = 32'h5;
      tick();
      for (int i = 0; i < 4; i++) begin
         if (i == 0) begin
            new_request = 1; addr = 32'h600; data = 32'h6;
         end else begin
            new_request = 0; store = 0;
         end
         mem_ack = 1;
         n_cmp++; if (lsq_full !== (i == 0)) begin
            n_bad++; $display("FAIL full_flag i=%0d got=%b exp=%b", i, lsq_full, (i == 0)); end
         n_cmp++; if (mem_request !== 1'b1 || mem_addr !== 32'h40 + 4 * i || mem_wdata !== i) begin
            n_bad++; $display("FAIL full_order i=%0d got=%b %h %h exp=1 %h %h",
                              i, mem_request, mem_addr, mem_wdata, 32'h40 + 4 * i, i); end
         tick();
      end
      new_request = 0; store = 0; mem_ack = 0;
      n_cmp++; if (mem_request !== 1'b0 || lsq_full !== 1'b0) begin
         n_bad++; $display("FAIL full_drain got=%b%b exp=00", mem_request, lsq_full); end
   endtask

   task automatic test_reset_wait_load();
      do_reset();
      new_request = 1; load = 1; addr = 32'h300; fn3 = 3'b010; mem_ack = 1;
      tick();
      new_request = 0; load = 0;
      tick();
      mem_ack = 0; rst = 1;
      tick();
      rst = 0; mem_rvalid = 1; mem_rdata = 32'h55;
      tick();
      mem_rvalid = 0; mem_rdata = '0;
      n_cmp++; if ({load_complete, lsq_full, mem_request} !== 3'b000 || load_data !== 32'h0) begin
         n_bad++; $display("FAIL rst_wait got=%b %h exp=000 0",
                           {load_complete, lsq_full, mem_request}, load_data); end
      tick();
      n_cmp++; if (load_complete !== 1'b0 || mem_request !== 1'b0) begin
         n_bad++; $display("FAIL rst_wait_late got=%b%b exp=00", load_complete, mem_request); end
   endtask

   task automatic test_invalid();
      do_reset();
      new_request = 1; load = 1; store = 1; addr = 32'h44; fn3 = 3'b010;
      tick();
      load = 0; store = 0;
      tick();
      new_request = 0;
      n_cmp++; if (mem_request !== 1'b0) begin
         n_bad++; $display("FAIL invalid_req got=%b exp=0", mem_request); end
      tick();
      n_cmp++; if (mem_request !== 1'b0 || lsq_full !== 1'b0) begin
         n_bad++; $display("FAIL invalid_idle got=%b%b exp=00", mem_request, lsq_full); end
   endtask

   task automatic test_random();
      req_t        q[$];
      req_t        r;
      logic        waiting = 0;
      logic        exp_lc = 0;
      logic [31:0] exp_ld = 0;
      logic        exp_req, accept;
      int          sel;
      do_reset();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         exp_req = !waiting && (q.size() > 0);
         n_cmp++; if (lsq_full !== (q.size() == DEPTH)) begin
            n_bad++; $display("FAIL rnd_full cyc=%0d got=%b exp=%b", cyc, lsq_full, (q.size() == DEPTH)); end
         n_cmp++; if (mem_request !== exp_req) begin
            n_bad++; $display("FAIL rnd_req cyc=%0d got=%b exp=%b", cyc, mem_request, exp_req); end
         if (exp_req) begin
            n_cmp++; if (mem_addr !== (q[0].a & 32'hFFFFFFFC) || mem_load !== q[0].ld || mem_store !== !q[0].ld) begin
               n_bad++; $display("FAIL rnd_head cyc=%0d got=%h %b%b exp=%h %b%b", cyc, mem_addr, mem_load,
                                 mem_store, q[0].a & 32'hFFFFFFFC, q[0].ld, !q[0].ld); end
            if (!q[0].ld) begin
               n_cmp++; if (mem_wdata !== m_wdata(q[0].f, q[0].d) || mem_be !== m_be(q[0].f, q[0].a)) begin
                  n_bad++; $display("FAIL rnd_store cyc=%0d got=%h %b exp=%h %b", cyc, mem_wdata, mem_be,
                                    m_wdata(q[0].f, q[0].d), m_be(q[0].f, q[0].a)); end
            end
         end else begin
            n_cmp++; if ({mem_addr, mem_wdata, mem_be, mem_load, mem_store} !== 70'h0) begin
               n_bad++; $display("FAIL rnd_idle_bus cyc=%0d got=%h %h %b %b%b", cyc, mem_addr, mem_wdata,
                                 mem_be, mem_load, mem_store); end
         end
         n_cmp++; if (load_complete !== exp_lc) begin
            n_bad++; $display("FAIL rnd_lc cyc=%0d got=%b exp=%b", cyc, load_complete, exp_lc); end
         if (exp_lc) begin
            n_cmp++; if (load_data !== exp_ld) begin
               n_bad++; $display("FAIL rnd_ld cyc=%0d got=%h exp=%h", cyc, load_data, exp_ld); end
         end

         new_request = ($urandom_range(0, 1) == 1);
         sel = $urandom_range(0, 9);
         load  = (sel == 0) || (sel >= 2 && sel < 6);
         store = (sel == 0) || (sel >= 6);
         addr  = $urandom;
         data  = $urandom;
         fn3   = 3'($urandom_range(0, 7));
         mem_ack    = ($urandom_range(0, 1) == 1);
         mem_rvalid = ($urandom_range(0, 4) < 2);
         mem_rdata  = $urandom;

         accept = new_request && (load != store) && (q.size() < DEPTH);
         exp_lc = 0;
         if (waiting) begin
            if (mem_rvalid) begin
               exp_ld  = m_load(q[0].f, q[0].a, mem_rdata);
               exp_lc  = 1;
               waiting = 0;
               void'(q.pop_front());
            end
         end else if (q.size() > 0 && mem_ack) begin
            if (q[0].ld) waiting = 1;
            else void'(q.pop_front());
         end
         if (accept) begin
            r.a = addr; r.d = data; r.f = fn3; r.ld = load;
            q.push_back(r);
         end
         tick();
      end
      idle_inputs();
   endtask

   initial begin
      rst = 1;
      idle_inputs();
      test_reset();
      test_sw();
      test_load(3'b000, 32'hFFFFFF80);
      test_load(3'b100, 32'h00000080);
      test_sh();
      test_full();
      test_reset_wait_load();
      test_invalid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
